// File: rtl/serial_to_parallel_pkg.sv
// Shared definitions for the serial-to-parallel stream converter.
//   order_e : first-beat placement (LSB_FIRST = lane 0, MSB_FIRST = top lane)
//   lanes_f : number of lane_w-bit beats per width-bit word
//   cnt_w_f : lane counter width, never below 1 bit
package serial_to_parallel_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } order_e;

  function automatic int unsigned lanes_f(input int unsigned width, input int unsigned lane_w);
    return (lane_w == 0) ? 0 : width / lane_w;
  endfunction

  function automatic int unsigned cnt_w_f(input int unsigned lanes);
    return (lanes <= 2) ? 1 : 32'($clog2(lanes));
  endfunction

endpackage

// File: rtl/stream_out_slot.sv
// One-entry registered ready/valid output slot.
//   clk, rst_n            : clock, async active-low reset
//   load                  : capture load_data/load_lanes (only asserted when free)
//   load_data, load_lanes : word and filled-lane count to capture
//   free                  : slot empty or draining this cycle
//   out_valid/out_ready   : downstream handshake
//   out_data, out_lanes   : held stable while stalled
module stream_out_slot #(
  parameter int unsigned data_w = 8,
  parameter int unsigned cnt_w  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [data_w-1:0] load_data,
  input  logic [cnt_w-1:0]  load_lanes,
  output logic              free,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w-1:0] out_data,
  output logic [cnt_w-1:0]  out_lanes
);

  assign free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lanes <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_lanes <= load_lanes;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_to_parallel_stream.sv
// Assembles width/lane_w input beats of lane_w bits into one width-bit word.
//   width, lane_w, msb_first : word size, beat size, first-beat placement
//   clk, rst_n               : clock, async active-low reset
//   in_valid/in_ready/in_data: input beat handshake
//   flush                    : single-cycle request to emit the partial word
//   out_valid/out_ready      : output handshake
//   out_data                 : assembled word, unfilled lanes zero
//   out_lanes                : number of filled lanes in out_data
module serial_to_parallel_stream
  import serial_to_parallel_pkg::*;
#(
  parameter int unsigned width     = 8,
  parameter int unsigned lane_w    = 1,
  parameter bit          msb_first = 1'b0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [lane_w-1:0]                             in_data,
  input  logic                                          flush,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [width-1:0]                              out_data,
  output logic [$clog2(lanes_f(width, lane_w)+1)-1:0]   out_lanes
);

  localparam int unsigned lanes = lanes_f(width, lane_w);
  localparam int unsigned cnt_w = cnt_w_f(lanes);
  localparam int unsigned ol_w  = $clog2(lanes + 1);
  localparam order_e      order = msb_first ? MSB_FIRST : LSB_FIRST;
  localparam logic [cnt_w-1:0] last_k = cnt_w'(lanes - 1);

  if (lane_w == 0 || width < lane_w || (width % lane_w) != 0) begin : g_bad_params
    $error("serial_to_parallel_stream: width must be a nonzero multiple of lane_w");
  end

  logic [width-1:0] acc;
  logic [cnt_w-1:0] k;
  logic             flush_pend;

  logic             free;
  logic             accept;
  logic             last;
  logic             complete;
  logic             req;
  logic             has_partial;
  logic             flush_go;
  logic             pend_set;
  logic             load;
  logic [cnt_w-1:0] lane_idx;
  logic [width-1:0] beat_word;
  logic [width-1:0] merged;
  logic [ol_w-1:0]  count_now;
  logic [ol_w-1:0]  load_lanes;

  assign last     = (k == last_k);
  // Only the final lane needs the slot; earlier lanes go into acc regardless.
  assign in_ready = !(last && !free) && !flush_pend;
  assign accept   = in_valid && in_ready;
  assign complete = accept && last;

  assign lane_idx  = (order == MSB_FIRST) ? (last_k - k) : k;
  assign beat_word = width'(in_data) << (lane_w * 32'(lane_idx));
  assign merged    = acc | (accept ? beat_word : '0);

  // A completing beat consumes the whole word, so a coincident flush sees nothing left.
  assign count_now   = ol_w'(k) + ol_w'(accept);
  assign req         = flush || flush_pend;
  assign has_partial = !complete && (count_now != '0);
  assign flush_go    = req && has_partial && free;
  assign pend_set    = req && has_partial && !free;

  assign load       = complete || flush_go;
  assign load_lanes = complete ? ol_w'(lanes) : count_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      k          <= '0;
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= pend_set;
      if (load) begin
        acc <= '0;
        k   <= '0;
      end else if (accept) begin
        acc <= merged;
        k   <= k + cnt_w'(1);
      end
    end
  end

  stream_out_slot #(
    .data_w (width),
    .cnt_w  (ol_w)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (merged),
    .load_lanes (load_lanes),
    .free       (free),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lanes  (out_lanes)
  );

  a_load_when_free: assert property (@(posedge clk) disable iff (!rst_n) load |-> free);

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
module tb_serial_to_parallel_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A: width 8, lane_w 1, lsb first
  logic       a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [0:0] a_in_data;
  logic [7:0] a_out_data;
  logic [3:0] a_out_lanes;
  // B: width 16, lane_w 4, msb first
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [3:0]  b_in_data;
  logic [15:0] b_out_data;
  logic [2:0]  b_out_lanes;
  // C: width 8, lane_w 2, lsb first
  logic       c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
  logic [1:0] c_in_data;
  logic [7:0] c_out_data;
  logic [2:0] c_out_lanes;

  serial_to_parallel_stream #(.width(8), .lane_w(1), .msb_first(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_lanes(a_out_lanes));

  serial_to_parallel_stream #(.width(16), .lane_w(4), .msb_first(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_lanes(b_out_lanes));

  serial_to_parallel_stream #(.width(8), .lane_w(2), .msb_first(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .flush(c_flush), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_lanes(c_out_lanes));

  // Scoreboards: {lanes, data} zero-extended to 32 bits
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  logic [7:0]  ma_acc = '0;
  int unsigned ma_cnt = 0;
  logic [15:0] mb_acc = '0;
  int unsigned mb_cnt = 0;
  logic [7:0]  mc_acc = '0;
  int unsigned mc_cnt = 0;

  int unsigned b_in_cnt = 0;
  int unsigned b_out_cnt = 0;
  bit          b_done = 1'b0;

  task automatic ma_add(input logic d);
    ma_acc[ma_cnt] = d;
    ma_cnt++;
    if (ma_cnt == 8) begin
      qa.push_back(32'({4'(8), ma_acc}));
      ma_acc = '0;
      ma_cnt = 0;
    end
  endtask

  task automatic ma_flush();
    if (ma_cnt != 0) begin
      qa.push_back(32'({4'(ma_cnt), ma_acc}));
      ma_acc = '0;
      ma_cnt = 0;
    end
  endtask

  task automatic mb_add(input logic [3:0] d);
    mb_acc[(3 - mb_cnt) * 4 +: 4] = d;
    mb_cnt++;
    if (mb_cnt == 4) begin
      qb.push_back(32'({3'(4), mb_acc}));
      mb_acc = '0;
      mb_cnt = 0;
    end
  endtask

  task automatic mc_add(input logic [1:0] d);
    mc_acc[mc_cnt * 2 +: 2] = d;
    mc_cnt++;
    if (mc_cnt == 4) begin
      qc.push_back(32'({3'(4), mc_acc}));
      mc_acc = '0;
      mc_cnt = 0;
    end
  endtask

  // Output monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      check("a_word_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) check("a_word", 32'({a_out_lanes, a_out_data}), qa.pop_front());
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      b_out_cnt++;
      check("b_word_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) check("b_word", 32'({b_out_lanes, b_out_data}), qb.pop_front());
    end
    if (rst_n && c_out_valid && c_out_ready) begin
      check("c_word_expected", 32'(qc.size() != 0), 32'd1);
      if (qc.size() != 0) check("c_word", 32'({c_out_lanes, c_out_data}), qc.pop_front());
    end
  end

  task automatic a_beat(input logic d);
    int unsigned n = 0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) check("a_in_ready_timeout", 32'(a_in_ready), 32'd1);
    else ma_add(d);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic b_beat(input logic [3:0] d);
    int unsigned n = 0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    @(negedge clk);
    while (!b_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_in_ready) check("b_in_ready_timeout", 32'(b_in_ready), 32'd1);
    else begin
      mb_add(d);
      b_in_cnt++;
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic c_beat(input logic [1:0] d, output int unsigned stalls);
    int unsigned n = 0;
    c_in_valid = 1'b1;
    c_in_data  = d;
    @(negedge clk);
    while (!c_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    stalls = n;
    if (!c_in_ready) check("c_in_ready_timeout", 32'(c_in_ready), 32'd1);
    else mc_add(d);
    @(posedge clk);
    #1;
    c_in_valid = 1'b0;
  endtask

  task automatic a_flush_pulse();
    a_flush = 1'b1;
    ma_flush();
    @(posedge clk);
    #1;
    a_flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 32'(qa.size() + qb.size() + qc.size()), 32'd0);
  endtask

  initial begin
    logic [7:0]  pat;
    logic [1:0]  cbeats[8];
    int unsigned st;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_flush = 1'b0; c_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_out_lanes", 32'(a_out_lanes), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    rst_n = 1'b1;

    // Continuous bits 1,0,1,0,... -> 8'h55 one cycle after the 8th beat
    for (int i = 0; i < 8; i++) begin
      a_beat(((i % 2) == 0) ? 1'b1 : 1'b0);
      if (i == 6) check("a_not_valid_early", 32'(a_out_valid), 32'd0);
    end
    check("a_latency_valid", 32'(a_out_valid), 32'd1);
    check("a_latency_data", 32'(a_out_data), 32'h55);
    check("a_latency_lanes", 32'(a_out_lanes), 32'd8);
    wait_drain("drain_t1");

    // MSB-first nibbles A,B,C,D -> 16'hABCD
    b_beat(4'hA); b_beat(4'hB); b_beat(4'hC); b_beat(4'hD);
    check("b_abcd_data", 32'(b_out_data), 32'hABCD);
    wait_drain("drain_t2a");

    // Random beats with random backpressure
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          b_beat(4'($urandom_range(0, 15)));
        end
        b_done = 1'b1;
      end
      begin
        while (!b_done) begin
          b_out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    b_out_ready = 1'b1;
    wait_drain("drain_t2b");
    check("b_in_count", 32'(b_in_cnt), 32'd1004);
    check("b_out_vs_in", 32'(b_out_cnt * 4), 32'(b_in_cnt));

    // Backpressure: only the last lane of the second word stalls
    cbeats = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    c_out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      c_beat(cbeats[i], st);
      check($sformatf("c_beat%0d_stalls", i), 32'(st), 32'd0);
    end
    check("c_slot_full", 32'(c_out_valid), 32'd1);
    c_in_valid = 1'b1;
    c_in_data  = cbeats[7];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("c_last_lane_stalled", 32'(c_in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    c_out_ready = 1'b1;
    @(negedge clk);
    check("c_last_lane_released", 32'(c_in_ready), 32'd1);
    mc_add(cbeats[7]);
    @(posedge clk);
    #1;
    c_in_valid = 1'b0;
    wait_drain("drain_t3");

    // Flush a 3-bit partial, then flush with nothing assembled
    a_beat(1'b1); a_beat(1'b1); a_beat(1'b1);
    a_flush_pulse();
    check("a_flush_valid", 32'(a_out_valid), 32'd1);
    check("a_flush_data", 32'(a_out_data), 32'h07);
    check("a_flush_lanes", 32'(a_out_lanes), 32'd3);
    a_flush_pulse();
    check("a_empty_flush_no_output", 32'(a_out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("a_empty_flush_still_idle", 32'(a_out_valid), 32'd0);
    wait_drain("drain_t4");

    // Flush while the slot is full stays pending until the drain
    a_out_ready = 1'b0;
    pat = 8'h96;
    for (int i = 0; i < 8; i++) a_beat(pat[i]);
    a_beat(1'b1); a_beat(1'b0);
    a_flush_pulse();
    for (int i = 0; i < 3; i++) begin
      check("a_pend_in_ready", 32'(a_in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("a_pend_emitted_valid", 32'(a_out_valid), 32'd1);
    check("a_pend_emitted_lanes", 32'(a_out_lanes), 32'd2);
    check("a_pend_in_ready_back", 32'(a_in_ready), 32'd1);
    wait_drain("drain_t5");

    // Reset mid-word with the slot full
    a_out_ready = 1'b0;
    pat = 8'hFF;
    for (int i = 0; i < 8; i++) a_beat(pat[i]);
    a_beat(1'b1); a_beat(1'b1); a_beat(1'b1);
    check("a_full_before_reset", 32'(a_out_valid), 32'd1);
    rst_n = 1'b0;
    qa.delete();
    ma_acc = '0;
    ma_cnt = 0;
    #1;
    check("a_reset_clears_valid", 32'(a_out_valid), 32'd0);
    check("a_reset_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    pat = 8'hC2;
    for (int i = 0; i < 8; i++) a_beat(pat[i]);
    check("a_post_reset_data", 32'(a_out_data), 32'hC2);
    wait_drain("drain_t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_to_parallel_stream.md
# serial_to_parallel_stream

Parametrised successor to the single-bit serial-to-parallel converter. It assembles `lanes = width / lane_w` input beats of `lane_w` bits into one `width`-bit word, with selectable first-beat placement. The output is a registered ready/valid slot with backpressure, and a flush control emits a partial word. It sits between a narrow serial front end and word-wide stream consumers.

## Interface
- `width`, 8: output word bits; must be a multiple of `lane_w`, ≥ `lane_w`.
- `lane_w`, 1: bits accepted per input beat.
- `msb_first`, 0: 0 = first beat lands in bits `[lane_w-1:0]`; 1 = first beat lands in the top lane.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_data` in `lane_w`: input beat.
- `flush` in 1: single-cycle request to emit the partially assembled word.
- `out_valid` out 1: output slot full.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `out_data` out `width`: assembled word; unfilled lanes are 0.
- `out_lanes` out `$clog2(lanes+1)`: number of filled lanes; equals `lanes` for a full word.

## Operation
- State:
  - assembly register `acc[width]`;
  - lane counter `k` (0..lanes-1, width `max(1,$clog2(lanes))`);
  - output slot (`out_valid`, `out_data`, `out_lanes`);
  - `flush_pend` flag.
- Accept:
  - The beat is written into lane `k`, or lane `lanes-1-k` when `msb_first`.
  - `k` increments.
- Completion:
  - Triggered when the accept fills lane `lanes-1`.
  - The word (acc merged with the current beat) loads the slot with `out_lanes = lanes`.
  - `acc` clears and `k` returns to 0.
- Slot free condition: `free = !out_valid || out_ready`.
- `in_ready = !(k == lanes-1 && !free) && !flush_pend`. This is a combinational path from `out_ready`; no register is allowed on this path.
- Flush:
  - The effective request is `flush || flush_pend`.
  - If the request is active, `free` is true, and the count including this cycle's accepted beat is > 0, the partial word loads the slot with `out_lanes = count`. Then `acc` and `k` clear and `flush_pend` clears.
  - If the request is active with count > 0 but the slot is not free, `flush_pend` sets and holds. `in_ready` is 0 while pending.
  - If the request is active with count 0, it is a no-op and `flush_pend` clears.
  - A beat that completes a full word in the same cycle as `flush` takes precedence; the flush then sees count 0 and becomes a no-op.
- `lanes == 1`: every accepted beat is a full word; flush is always a no-op.

## Timing
- Reset values (async assert, sync deassert by the environment):
  - `out_valid=0`, `out_data=0`, `out_lanes=0`, `acc=0`, `k=0`, `flush_pend=0`.
  - Hence `in_ready=1`.
- Latency: the last lane accepted at edge N gives `out_valid=1` with the word after edge N. A flush sampled at edge N gives the partial word after edge N, if the slot was free.
- Throughput: one beat per cycle sustained while `out_ready=1`, including back-to-back words (slot load and drain in the same cycle).
- Backpressure: only the final lane of a word stalls. Beats 0..lanes-2 are accepted while the slot is full.
- `out_data` and `out_lanes` are stable while `out_valid && !out_ready`.
- Reset mid-word or mid-stall discards `acc`, the slot, and the pending flush immediately.

## Structure
- Package `serial_to_parallel_pkg`:
  - `lanes_f(width, lane_w)` and `cnt_w_f(lanes)` (`max(1,$clog2)`) functions;
  - `order_e` enum (`LSB_FIRST`, `MSB_FIRST`) for documentation and assertions.
- Sub-module `stream_out_slot`: parametrised-width one-entry ready/valid register with load/free logic. The top holds assembly, counter, and flush control.
- Parameter legality is checked by an elaboration-time `$error`.

## Test plan
- `width=8, lane_w=1, msb_first=0`, continuous bits `1,0,1,0,1,0,1,0`, `out_ready=1` → one word `8'h55`, `out_lanes=8`, valid one cycle after the 8th beat.
- `width=16, lane_w=4, msb_first=1`, beats `A,B,C,D` → `16'hABCD`. Then 1000 random beats against a queue model → all words match and `out_count*lanes == in_count`.
- `width=8, lane_w=2`, `out_ready=0`, send 8 beats:
  - the first word fills the slot;
  - beats 5-7 are accepted;
  - `in_ready=0` on beat 8 until `out_ready=1`;
  - no beat is lost.
- `width=8, lane_w=1`: 3 bits `1,1,1` then `flush` → `out_data=8'h07`, `out_lanes=3`. Flush on an empty accumulator → no output.
- Flush while the slot is full: `flush_pend` holds and `in_ready=0`. After the drain, the partial word is emitted and `in_ready` returns to 1.
- Assert `rst_n` low mid-word with the slot full → `out_valid=0` immediately. After release, a new word assembles from lane 0 with no stale bits.
